// File: rtl/matmul_seq_if.sv
// fixedp: shared clock/reset bundle and fixed-point format parameters.
// Ports: clk (input); carries reset plus WIDTH/SCALE for the Q-format.
interface fixedp #(
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    input logic clk
);
    logic reset;

    modport dut (
        input clk,
        input reset
    );
endinterface

// File: rtl/matmul_seq.sv
// matmul_seq: sequential fixed-point matrix multiply F = A*B using one
// time-shared MAC. Ports: g (clk/reset), start, a, b -> f, busy, done.
module matmul_seq #(
    parameter int ROWS  = 1,
    parameter int INNER = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 16,
    parameter int SCALE = 8
) (
    fixedp.dut                                g,
    input  logic                              start,
    input  logic [ROWS:1][INNER:1][WIDTH-1:0] a,
    input  logic [INNER:1][COLS:1][WIDTH-1:0] b,
    output logic [ROWS:1][COLS:1][WIDTH-1:0]  f,
    output logic                              busy,
    output logic                              done
);

    localparam int AW = 2 * WIDTH + $clog2(INNER) + 1;
    localparam int RW = $clog2(ROWS + 1);
    localparam int KW = $clog2(INNER + 1);
    localparam int CW = $clog2(COLS + 1);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                           state_q;
    logic [RW-1:0]                    i_q;
    logic [CW-1:0]                    j_q;
    logic [KW-1:0]                    k_q;
    logic signed [AW-1:0]             acc_q;
    logic [ROWS:1][COLS:1][WIDTH-1:0] f_q;
    logic                             busy_q;
    logic                             done_q;

    logic signed [WIDTH-1:0]   a_el;
    logic signed [WIDTH-1:0]   b_el;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      sum_d;
    logic signed [AW-1:0]      shifted;
    logic [WIDTH-1:0]          conv;
    logic                      i_last;
    logic                      j_last;
    logic                      k_last;

    // MAC datapath and output conversion for the current (i,j,k).
    always_comb begin
        a_el    = a[i_q][k_q];
        b_el    = b[k_q][j_q];
        prod    = a_el * b_el;
        sum_d   = acc_q + AW'(prod);
        // Arithmetic shift floors toward minus infinity.
        shifted = sum_d >>> SCALE;
        if (shifted > SAT_MAX) begin
            conv = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            conv = SAT_MIN[WIDTH-1:0];
        end else begin
            conv = shifted[WIDTH-1:0];
        end
        i_last = (i_q == RW'(ROWS));
        j_last = (j_q == CW'(COLS));
        k_last = (k_q == KW'(INNER));
    end

    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            state_q <= IDLE;
            // Indices rest at the first element so reads stay in range.
            i_q     <= RW'(1);
            j_q     <= CW'(1);
            k_q     <= KW'(1);
            acc_q   <= '0;
            f_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        i_q     <= RW'(1);
                        j_q     <= CW'(1);
                        k_q     <= KW'(1);
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    if (k_last) begin
                        // Element complete: commit it, restart the sum.
                        f_q[i_q][j_q] <= conv;
                        acc_q         <= '0;
                        k_q           <= KW'(1);
                        if (j_last) begin
                            j_q <= CW'(1);
                            if (i_last) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                i_q <= i_q + RW'(1);
                            end
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end else begin
                        acc_q <= sum_d;
                        k_q   <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign f    = f_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_matmul_seq.sv
// tb_matmul_seq: directed + random checks of matmul_seq (2x2x2 and 1x1x1)
// against an arithmetic reference model.
module tb_matmul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    fixedp #(.WIDTH(16), .SCALE(8)) g (.clk(clk));

    logic        start1, start2;
    logic [15:0] a1, b1, f1;
    logic [63:0] a2, b2, f2;
    logic        busy1, done1, busy2, done2;

    int ncmp  = 0;
    int nfail = 0;

    logic signed [15:0] ma [1:2][1:2];
    logic signed [15:0] mb [1:2][1:2];

    matmul_seq #(
        .ROWS(2), .INNER(2), .COLS(2), .WIDTH(16), .SCALE(8)
    ) u2 (
        .g(g), .start(start2), .a(a2), .b(b2),
        .f(f2), .busy(busy2), .done(done2)
    );

    matmul_seq #(
        .ROWS(1), .INNER(1), .COLS(1), .WIDTH(16), .SCALE(8)
    ) u1 (
        .g(g), .start(start1), .a(a1), .b(b1),
        .f(f1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat(longint s);
        longint t;
        t = s >>> 8;
        if (t > 32767) t = 32767;
        else if (t < -32768) t = -32768;
        return t[15:0];
    endfunction

    function automatic logic [63:0] ref2();
        logic [63:0] r;
        longint s;
        r = '0;
        for (int i = 1; i <= 2; i++) begin
            for (int j = 1; j <= 2; j++) begin
                s = 0;
                for (int k = 1; k <= 2; k++)
                    s += longint'(ma[i][k]) * longint'(mb[k][j]);
                r[((i-1)*2 + (j-1))*16 +: 16] = sat(s);
            end
        end
        return r;
    endfunction

    task automatic load2();
        for (int r = 1; r <= 2; r++) begin
            for (int c = 1; c <= 2; c++) begin
                a2[((r-1)*2 + (c-1))*16 +: 16] = ma[r][c];
                b2[((r-1)*2 + (c-1))*16 +: 16] = mb[r][c];
            end
        end
    endtask

    task automatic rand2(bit wide);
        for (int r = 1; r <= 2; r++) begin
            for (int c = 1; c <= 2; c++) begin
                if (wide) begin
                    ma[r][c] = 16'($urandom);
                    mb[r][c] = 16'($urandom);
                end else begin
                    ma[r][c] = 16'($urandom_range(0, 1023)) - 16'd512;
                    mb[r][c] = 16'($urandom_range(0, 1023)) - 16'd512;
                end
            end
        end
    endtask

    // Start accepted at edge 0; busy cycles 1..8, done in cycle 9.
    task automatic run2(string tag, bit poke);
        logic [63:0] e;
        e = ref2();
        load2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check({tag, " busy"}, 64'(busy2), 64'd1);
            check({tag, " done early"}, 64'(done2), 64'd0);
            if (poke && c == 3) start2 = 1'b1;
            if (poke && c == 5) start2 = 1'b0;
            tick();
        end
        check({tag, " done"}, 64'(done2), 64'd1);
        check({tag, " busy at done"}, 64'(busy2), 64'd0);
        check({tag, " f"}, f2, e);
        if (poke) start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check({tag, " done after"}, 64'(done2), 64'd0);
        check({tag, " idle"}, 64'(busy2), 64'd0);
        check({tag, " f held"}, f2, e);
    endtask

    task automatic run1(string tag, logic [15:0] av, logic [15:0] bv);
        logic [15:0] e;
        e = sat(longint'($signed(av)) * longint'($signed(bv)));
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, " busy"}, 64'(busy1), 64'd1);
        check({tag, " done early"}, 64'(done1), 64'd0);
        tick();
        check({tag, " done"}, 64'(done1), 64'd1);
        check({tag, " f"}, 64'(f1), 64'(e));
        tick();
        check({tag, " done after"}, 64'(done1), 64'd0);
    endtask

    initial begin
        g.reset = 1'b1;
        start1  = 1'b1;
        start2  = 1'b1;
        a1 = 16'h1234;
        b1 = 16'h0567;
        a2 = '1;
        b2 = '1;
        tick();
        tick();
        check("rst f2", f2, 64'd0);
        check("rst f1", 64'(f1), 64'd0);
        check("rst busy2", 64'(busy2), 64'd0);
        check("rst done2", 64'(done2), 64'd0);
        check("rst busy1", 64'(busy1), 64'd0);
        g.reset = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        tick();

        ma[1][1] = 16'h0100; ma[1][2] = 16'h0000;
        ma[2][1] = 16'h0000; ma[2][2] = 16'h0100;
        mb[1][1] = 16'h0200; mb[1][2] = 16'hFF80;
        mb[2][1] = 16'h0040; mb[2][2] = 16'h0300;
        run2("ident", 1'b0);
        check("ident f=B", f2, 64'h0300_0040_FF80_0200);

        run1("neg1x1.5", 16'hFF00, 16'h0180);
        run1("floor", 16'h0001, 16'hFFFF);
        run1("satpos", 16'h7FFF, 16'h7FFF);
        run1("satneg", 16'h8000, 16'h7FFF);
        check("satneg f", 64'(f1), 64'h8000);

        run2("ident poke", 1'b1);

        for (int n = 0; n < 6; n++) begin
            rand2(n[0]);
            run2($sformatf("rand2_%0d", n), n == 3);
        end

        for (int n = 0; n < 8; n++)
            run1($sformatf("rand1_%0d", n), 16'($urandom), 16'($urandom));

        rand2(1'b0);
        load2();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        tick();
        tick();
        g.reset = 1'b1;
        start2  = 1'b1;
        tick();
        check("midrst f", f2, 64'd0);
        check("midrst busy", 64'(busy2), 64'd0);
        check("midrst done", 64'(done2), 64'd0);
        g.reset = 1'b0;
        start2  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("post rst done", 64'(done2), 64'd0);
            check("post rst busy", 64'(busy2), 64'd0);
            tick();
        end
        run2("after rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter ROWS, default 1: rows of A and F.
REQ-002 Parameter INNER, default 1: columns of A, rows of B; must be >= 1.
REQ-003 Parameter COLS, default 1: columns of B and F.
REQ-004 g.clk  input (via fixedp g)  1  sole clock; all state updates on its rising edge.
REQ-005 g.reset  input (via fixedp g)  1  reset, synchronous, active-high.
REQ-006 g  interface  --  fixedp parameters and common ports; supplies WIDTH (element bits, signed two's complement) and SCALE (fraction bits).
REQ-007 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-008 a  input  [ROWS:1][INNER:1][WIDTH]  left operand; must be held stable from start acceptance until done.
REQ-009 b  input  [INNER:1][COLS:1][WIDTH]  right operand; same stability rule as a.
REQ-010 f  output  [ROWS:1][COLS:1][WIDTH]  registered product F = A*B; feeds matadd3b2 operand ports.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  single-cycle pulse; f fully valid in that cycle and held until next accepted start.

Function
REQ-013 A single multiply-accumulate datapath shall be time-shared; one MAC per RUN cycle.
REQ-014 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after the last MAC; DONE->IDLE unconditionally next cycle.
REQ-015 start in RUN or DONE shall be ignored (no restart, no queuing).
REQ-016 Iteration order: i (row) outer, j (col) middle, k (inner) innermost, all 1-based, ascending.
REQ-017 Each MAC: acc += signed(a[i][k]) * signed(b[k][j]); acc width 2*WIDTH + clog2(INNER)+1, no overflow possible.
REQ-018 On the k=INNER cycle the completed sum (including that term) shall be converted and written to f[i][j] at that edge; acc cleared for the next element.
REQ-019 Conversion: arithmetic shift right by SCALE (truncation toward minus infinity), then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 Latency: with start accepted at edge 0, RUN occupies N = ROWS*COLS*INNER cycles and done is high in cycle N+1.
REQ-021 Back-to-back: earliest next start acceptance is the cycle after done (IDLE); minimum period N+2 cycles.
REQ-022 f elements not yet recomputed in a run shall retain previous values; consumers use f only at or after done.
REQ-023 INNER=1 shall work (every RUN cycle writes one element).

Reset
REQ-024 g.reset=1 at a clock edge shall force IDLE, clear acc and all indices, set f to all zeros, busy=0, done=0.
REQ-025 Reset mid-RUN shall abort the operation with no done pulse; reset takes priority over start in the same cycle.
REQ-026 First start after reset release shall be accepted normally.

Verification (WIDTH=16, SCALE=8, 1.0 = 0x0100)
REQ-027 ROWS=INNER=COLS=2, A=identity (0x0100 diag), B={{0x0200,0xFF80},{0x0040,0x0300}}, start at cycle 0 -> busy cycles 1..8, done only in cycle 9, f=B.
REQ-028 1x1x1, a=0xFF00 (-1.0), b=0x0180 (1.5) -> f=0xFE80 (-1.5); a=0x0001, b=0xFFFF -> f=0xFFFF (floor of -1/256).
REQ-029 1x1x1, a=b=0x7FFF -> f=0x7FFF (positive saturation); a=0x8000, b=0x7FFF -> f=0x8000 (negative saturation).
REQ-030 2x2x2 run, start pulsed again during RUN and in DONE -> ignored; exactly one done pulse at cycle 9; result unchanged.
REQ-031 Reset asserted at cycle 4 of a 2x2x2 run -> cycle 5: f all zero, busy=0, no done; new start then yields correct f with done N+1 cycles later.
